// File: rtl/fdtd_calc_ez_stream.sv
// Streaming Ez update for one 1-D line: Ez_new[k] = Ceze*Ez_old[k] + Cezh*(Hy[k]-Hy[k-1]).
// Three-stage pipeline between ready/valid streams, PEC boundary (Hy[-1]=0) at cell 0.
`timescale 1ns/1ps
module fdtd_calc_ez_stream #(
    parameter int FDTD_DATA_WIDTH = 32,
    parameter int CUT_LT          = 51,
    parameter int CUT_RT          = 21,
    parameter int NCELL_WIDTH     = 10
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       start,
    input  logic [NCELL_WIDTH-1:0]     ncell,
    input  logic [FDTD_DATA_WIDTH-1:0] Ceze,
    input  logic [FDTD_DATA_WIDTH-1:0] Cezh,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [FDTD_DATA_WIDTH-1:0] Hy_i,
    input  logic [FDTD_DATA_WIDTH-1:0] Ez_old_i,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [FDTD_DATA_WIDTH-1:0] Ez_n_o,
    output logic                       out_last,
    output logic                       busy,
    output logic                       done,
    output logic [1:0]                 state_dbg
);

    localparam int W = FDTD_DATA_WIDTH;

    // Handshakes: a beat transfers on a rising edge where valid & ready are both 1;
    // valid never depends on ready, and in_ready depends combinationally on out_ready.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [NCELL_WIDTH-1:0] ncell_q, in_cnt, in_cnt_nxt;
    logic [W-1:0]           ceze_q, cezh_q, hy_prev;
    logic                   adv, in_fire;
    logic                   start_line, zero_line, line_end;

    logic                   s1_valid, s1_last;
    logic [W-1:0]           s1_diff, s1_ez;
    logic                   s2_valid, s2_last;
    logic [2*W-1:0]         s2_p0, s2_p1;
    logic                   s3_valid, s3_last;
    logic [W-1:0]           s3_ez;

    // Keep the sign bit plus the fixed-point window; the rest of the product is dropped.
    function automatic logic [W-1:0] cut(input logic [2*W-1:0] p);
        return {p[2*W-1], p[CUT_LT:CUT_RT]};
    endfunction

    function automatic logic [2*W-1:0] smul(input logic [W-1:0] a, input logic [W-1:0] b);
        return {{W{a[W-1]}}, a} * {{W{b[W-1]}}, b};
    endfunction

    assign adv        = !s3_valid || out_ready;
    assign in_fire    = in_valid && in_ready;
    assign in_cnt_nxt = in_cnt + NCELL_WIDTH'(1);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        start_line = 1'b0;
        zero_line  = 1'b0;
        line_end   = 1'b0;
        in_ready   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    start_line = 1'b1;
                    if (ncell == '0) zero_line = 1'b1;
                    else             state_nxt = RUN;
                end
            end
            RUN: begin
                in_ready = adv && (in_cnt < ncell_q);
                if (in_valid && adv && (in_cnt < ncell_q) && (in_cnt_nxt == ncell_q))
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                if (s3_valid && out_ready && s3_last) begin
                    state_nxt = IDLE;
                    line_end  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ncell_q  <= '0;
            ceze_q   <= '0;
            cezh_q   <= '0;
            in_cnt   <= '0;
            hy_prev  <= '0;
            done     <= 1'b0;
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_diff  <= '0;
            s1_ez    <= '0;
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_p0    <= '0;
            s2_p1    <= '0;
            s3_valid <= 1'b0;
            s3_last  <= 1'b0;
            s3_ez    <= '0;
        end else begin
            done <= zero_line || line_end;
            if (start_line) begin
                ncell_q <= ncell;
                ceze_q  <= Ceze;
                cezh_q  <= Cezh;
                in_cnt  <= '0;
                hy_prev <= '0;
            end else if (in_fire) begin
                in_cnt  <= in_cnt_nxt;
                hy_prev <= Hy_i;
            end
            // All stages move together so a stalled S3 freezes the whole pipe.
            if (adv) begin
                s1_valid <= in_fire;
                s1_last  <= in_fire && (in_cnt_nxt == ncell_q);
                s1_diff  <= Hy_i - hy_prev;
                s1_ez    <= Ez_old_i;
                s2_valid <= s1_valid;
                s2_last  <= s1_last;
                s2_p0    <= smul(s1_ez, ceze_q);
                s2_p1    <= smul(s1_diff, cezh_q);
                s3_valid <= s2_valid;
                s3_last  <= s2_last;
                s3_ez    <= cut(s2_p0) + cut(s2_p1);
            end
        end
    end

    assign out_valid = s3_valid;
    assign out_last  = s3_last;
    assign Ez_n_o    = s3_ez;
    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule
